multi_port_stream_serializer: RTL and testbench
===============================================

MULTI_PORT_STREAM_SERIALIZER -- requirements
Module: multi_port_stream_serializer

Interface
REQ-001 SHALL have parameter InWidth, default 2, number of input lanes (>=1).
REQ-002 SHALL have parameter DataWidth, default 32, payload bits per lane.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port in_vld_i  input  InWidth  per-lane valid; lane 0 is oldest.
REQ-006 SHALL have port in_payload_i  input  InWidth x DataWidth  per-lane payload.
REQ-007 SHALL have port in_rdy_o  output  InWidth  per-lane ready.
REQ-008 SHALL have port out_vld_o  output  1  serial output valid.
REQ-009 SHALL have port out_payload_o  output  DataWidth  serial output payload.
REQ-010 SHALL have port out_rdy_i  input  1  serial output ready.
REQ-011 SHALL have port flush_i  input  1  discard all buffered entries.
REQ-012 SHALL have port cnt_o  output  clog2(InWidth+1)  number of buffered entries.

Function
REQ-013 SHALL hold an internal buffer of InWidth entries, occupancy cnt, read index rd_idx.
REQ-014 Accepted lanes SHALL be the contiguous valid prefix from lane 0; lanes at or after the first invalid lane SHALL be ignored with in_rdy_o low.
REQ-015 load_en SHALL be (cnt==0) or (cnt==1 and out_vld_o and out_rdy_i), and flush_i low.
REQ-016 in_rdy_o[i] SHALL be load_en AND in_vld_i[0..i] all high; the combinational path from in_vld_i to in_rdy_o is permitted.
REQ-017 On load with k accepted lanes (k>=1), the next cycle SHALL have cnt=k, rd_idx=0, buffer[j]=in_payload_i[j] for j<k.
REQ-018 out_vld_o SHALL equal (cnt!=0); out_payload_o SHALL equal buffer[rd_idx]; both registered, so there is no input-to-output combinational path.
REQ-019 Latency SHALL be 1 cycle from an input handshake to out_vld_o high for lane 0 data.
REQ-020 Each out_vld_o and out_rdy_i cycle SHALL decrement cnt and increment rd_idx; output order SHALL be lane 0..k-1.
REQ-021 A drain of the last entry and a new load in the same cycle SHALL produce no output bubble; sustained throughput SHALL be 1 entry per cycle.
REQ-022 out_vld_o SHALL remain asserted, with payload stable, while out_rdy_i is low (AXI-style hold).
REQ-023 flush_i high SHALL set cnt=0 and rd_idx=0 next cycle, force in_rdy_o low, and override a simultaneous load or drain.
REQ-024 cnt_o SHALL equal cnt; cnt SHALL never exceed InWidth.

Reset
REQ-025 When rstn is low at a clock edge, cnt, rd_idx, out_vld_o and cnt_o SHALL become 0, and in_rdy_o SHALL be 0 during reset.
REQ-026 Buffer payload storage SHALL NOT be reset.
REQ-027 Reset asserted mid-drain SHALL discard remaining entries with no further out_vld_o.

Structure
REQ-028 The count-width helper and lane-count constants SHALL live in the shared queue package alongside the FIFO typedefs.
REQ-029 Prefix-valid mask and popcount SHALL be one sub-module, stream_prefix_count, reusable by multi-port enqueue logic.
REQ-030 The control logic SHALL be no more than about 300 lines of RTL with no latches.

Verification
REQ-031 Scenario 1: InWidth=2, in_vld_i=2'b11 with payloads A,B and out_rdy_i=1 -> out A then B on consecutive cycles, and in_rdy_o=2'b11 again on the B cycle.
REQ-032 Scenario 2: in_vld_i=2'b10 -> in_rdy_o=2'b00, nothing accepted, out_vld_o stays 0.
REQ-033 Scenario 3: load A,B and hold out_rdy_i=0 for 5 cycles -> out_vld_o=1 with payload A stable, cnt_o=2, in_rdy_o=0.
REQ-034 Scenario 4: flush_i pulse while cnt_o=2 and in_vld_i=2'b11 -> next cycle cnt_o=0, out_vld_o=0, nothing loaded.
REQ-035 Scenario 5: rstn low during drain with cnt_o=1 -> next cycle out_vld_o=0, cnt_o=0.
REQ-036 Scenario 6: 1e6 random cycles feeding from a multi-port stream FIFO dequeue side, checked against a golden queue -> order preserved, count matches each cycle.

Source files
------------

// File: rtl/multi_port_stream_serializer_pkg.sv
// Shared queue package: lane-count constants, count/index width helpers
// and the queue operation type used by the multi-port stream logic.
package multi_port_stream_serializer_pkg;

  localparam int unsigned DefaultInWidth   = 2;
  localparam int unsigned DefaultDataWidth = 32;

  typedef enum logic [1:0] {
    QOP_HOLD  = 2'd0,
    QOP_LOAD  = 2'd1,
    QOP_DRAIN = 2'd2,
    QOP_CLEAR = 2'd3
  } q_op_e;

  // Bits needed to hold an occupancy of 0..lanes.
  function automatic int unsigned cnt_width(input int unsigned lanes);
    return $clog2(lanes + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/multi_port_stream_serializer_prefix_count.sv
// Contiguous valid-prefix mask from lane 0 and its population count.
module stream_prefix_count
  import multi_port_stream_serializer_pkg::*;
#(
  parameter int unsigned Lanes = DefaultInWidth
) (
  input  logic [Lanes-1:0]            vld,
  output logic [Lanes-1:0]            mask,
  output logic [cnt_width(Lanes)-1:0] count
);

  localparam int unsigned CntW = cnt_width(Lanes);

  logic run;

  always_comb begin
    mask  = '0;
    count = '0;
    run   = 1'b1;
    for (int i = 0; i < Lanes; i++) begin
      run     = run & vld[i];
      mask[i] = run;
      count   = count + CntW'(run);
    end
  end

endmodule

// File: rtl/multi_port_stream_serializer.sv
// Parallel-to-serial stream stage: captures the valid lane prefix in one
// cycle and replays it lane 0 first on a single valid/ready output.
module multi_port_stream_serializer
  import multi_port_stream_serializer_pkg::*;
#(
  parameter int unsigned InWidth   = DefaultInWidth,
  parameter int unsigned DataWidth = DefaultDataWidth
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [InWidth-1:0]                in_vld_i,
  input  logic [InWidth-1:0][DataWidth-1:0] in_payload_i,
  output logic [InWidth-1:0]                in_rdy_o,
  output logic                              out_vld_o,
  output logic [DataWidth-1:0]              out_payload_o,
  input  logic                              out_rdy_i,
  input  logic                              flush_i,
  output logic [cnt_width(InWidth)-1:0]     cnt_o
);

  localparam int unsigned CntW = cnt_width(InWidth);
  localparam int unsigned IdxW = idx_width(InWidth);

  logic [CntW-1:0]      cnt;
  logic [IdxW-1:0]      rd_idx;
  logic [CntW-1:0]      take_cnt;
  logic [InWidth-1:0]   take_mask;
  logic [DataWidth-1:0] buffer [InWidth];
  logic                 drain;
  logic                 load_en;
  q_op_e                op;

  stream_prefix_count #(
    .Lanes (InWidth)
  ) u_prefix (
    .vld   (in_vld_i),
    .mask  (take_mask),
    .count (take_cnt)
  );

  assign out_vld_o     = (cnt != '0);
  assign out_payload_o = buffer[rd_idx];
  assign cnt_o         = cnt;
  assign drain         = out_vld_o && out_rdy_i;

  // Reload is allowed when empty, or when the last entry leaves this cycle,
  // which keeps back-to-back groups bubble-free.
  assign load_en  = rstn && !flush_i &&
                    ((cnt == '0) || ((cnt == CntW'(1)) && drain));
  assign in_rdy_o = {InWidth{load_en}} & take_mask;

  always_comb begin
    op = QOP_HOLD;
    if (flush_i) begin
      op = QOP_CLEAR;
    end else if (load_en && (take_cnt != '0)) begin
      op = QOP_LOAD;
    end else if (drain) begin
      op = QOP_DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt    <= '0;
      rd_idx <= '0;
    end else begin
      case (op)
        QOP_CLEAR: begin
          cnt    <= '0;
          rd_idx <= '0;
        end
        QOP_LOAD: begin
          cnt    <= take_cnt;
          rd_idx <= '0;
        end
        QOP_DRAIN: begin
          cnt    <= cnt - CntW'(1);
          rd_idx <= (cnt == CntW'(1)) ? '0 : rd_idx + IdxW'(1);
        end
        default: ;
      endcase
    end
  end

  // Payload storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (op == QOP_LOAD) begin
      for (int j = 0; j < InWidth; j++) begin
        if (take_mask[j]) buffer[j] <= in_payload_i[j];
      end
    end
  end

endmodule

// File: tb/tb_multi_port_stream_serializer.sv
// Directed table plus corner-case sequences and a queue-model random run
// for the two-lane stream serializer.
module tb_multi_port_stream_serializer;

  logic             clk = 1'b0;
  logic             rstn;
  logic [1:0]       in_vld_i;
  logic [1:0][31:0] in_payload_i;
  logic [1:0]       in_rdy_o;
  logic             out_vld_o;
  logic [31:0]      out_payload_o;
  logic             out_rdy_i;
  logic             flush_i;
  logic [1:0]       cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  multi_port_stream_serializer #(
    .InWidth   (2),
    .DataWidth (32)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .in_vld_i      (in_vld_i),
    .in_payload_i  (in_payload_i),
    .in_rdy_o      (in_rdy_o),
    .out_vld_o     (out_vld_o),
    .out_payload_o (out_payload_o),
    .out_rdy_i     (out_rdy_i),
    .flush_i       (flush_i),
    .cnt_o         (cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rstn;
    logic        flush;
    logic [1:0]  vld;
    logic [31:0] p0;
    logic [31:0] p1;
    logic        ordy;
    logic        chk_state;
    logic [1:0]  exp_rdy;
    logic        exp_vld;
    logic [1:0]  exp_cnt;
    logic [31:0] exp_pay;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] PA = 32'hAAAA_0001;
  localparam logic [31:0] PB = 32'hBBBB_0002;
  localparam logic [31:0] PC = 32'hCCCC_0003;
  localparam logic [31:0] PD = 32'hDDDD_0004;
  localparam logic [31:0] PE = 32'hEEEE_0005;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic r, input logic f, input logic [1:0] v,
                       input logic [31:0] p0, input logic [31:0] p1, input logic ordy);
    @(negedge clk);
    rstn            = r;
    flush_i         = f;
    in_vld_i        = v;
    in_payload_i[0] = p0;
    in_payload_i[1] = p1;
    out_rdy_i       = ordy;
    #1;
  endtask

  task automatic check_state(input string tag, input logic [1:0] rdy, input logic vld,
                             input logic [1:0] cnt, input logic [31:0] pay);
    check({tag, " in_rdy"}, 64'(in_rdy_o), 64'(rdy));
    check({tag, " out_vld"}, 64'(out_vld_o), 64'(vld));
    check({tag, " cnt"}, 64'(cnt_o), 64'(cnt));
    if (vld) check({tag, " payload"}, 64'(out_payload_o), 64'(pay));
  endtask

  initial begin
    rstn = 1'b0; flush_i = 1'b0; in_vld_i = '0; in_payload_i = '0; out_rdy_i = 1'b0;

    //               rstn  fl  vld    p0  p1  ordy chk rdy    vld  cnt   pay
    vecs.push_back('{1'b0, 1'b0, 2'b11, PA, PB, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 2'b00, PA, PB, 1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 32'h0});
    // two-lane load then drain, with a reload on the last-entry cycle
    vecs.push_back('{1'b1, 1'b0, 2'b11, PA, PB, 1'b1, 1'b1, 2'b11, 1'b0, 2'd0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 2'b00, PE, PE, 1'b1, 1'b1, 2'b00, 1'b1, 2'd2, PA});
    vecs.push_back('{1'b1, 1'b0, 2'b11, PC, PD, 1'b1, 1'b1, 2'b11, 1'b1, 2'd1, PB});
    vecs.push_back('{1'b1, 1'b0, 2'b00, PE, PE, 1'b1, 1'b1, 2'b00, 1'b1, 2'd2, PC});
    vecs.push_back('{1'b1, 1'b0, 2'b00, PE, PE, 1'b1, 1'b1, 2'b00, 1'b1, 2'd1, PD});
    // non-prefix valid is ignored
    vecs.push_back('{1'b1, 1'b0, 2'b10, PA, PB, 1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 2'b00, PA, PB, 1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 32'h0});
    // single-lane load, held output, no load while one entry is stalled
    vecs.push_back('{1'b1, 1'b0, 2'b01, PE, PA, 1'b0, 1'b1, 2'b01, 1'b0, 2'd0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 2'b00, PA, PA, 1'b0, 1'b1, 2'b00, 1'b1, 2'd1, PE});
    vecs.push_back('{1'b1, 1'b0, 2'b11, PA, PB, 1'b0, 1'b1, 2'b00, 1'b1, 2'd1, PE});
    vecs.push_back('{1'b1, 1'b0, 2'b00, PA, PB, 1'b1, 1'b1, 2'b00, 1'b1, 2'd1, PE});
    vecs.push_back('{1'b1, 1'b0, 2'b00, PA, PB, 1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 32'h0});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rstn, vecs[i].flush, vecs[i].vld, vecs[i].p0, vecs[i].p1, vecs[i].ordy);
      if (vecs[i].chk_state)
        check_state($sformatf("vec%0d", i), vecs[i].exp_rdy, vecs[i].exp_vld,
                    vecs[i].exp_cnt, vecs[i].exp_pay);
      else
        check($sformatf("vec%0d in_rdy", i), 64'(in_rdy_o), 64'(vecs[i].exp_rdy));
    end

    // Stall: output held with payload A for five cycles, inputs blocked.
    drive(1'b1, 1'b0, 2'b11, PA, PB, 1'b0);
    check_state("stall load", 2'b11, 1'b0, 2'd0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 2'b11, PC, PD, 1'b0);
      check_state($sformatf("stall%0d", i), 2'b00, 1'b1, 2'd2, PA);
    end

    // Flush with cnt=2 and both lanes valid: nothing is loaded.
    drive(1'b1, 1'b1, 2'b11, PC, PD, 1'b1);
    check_state("flush pre", 2'b00, 1'b1, 2'd2, PA);
    drive(1'b1, 1'b0, 2'b00, PC, PD, 1'b1);
    check_state("flush post", 2'b00, 1'b0, 2'd0, 32'h0);
    drive(1'b1, 1'b0, 2'b00, PC, PD, 1'b1);
    check_state("flush post2", 2'b00, 1'b0, 2'd0, 32'h0);

    // Reset mid-drain with one entry left.
    drive(1'b1, 1'b0, 2'b11, PA, PB, 1'b1);
    check_state("rst load", 2'b11, 1'b0, 2'd0, 32'h0);
    drive(1'b1, 1'b0, 2'b00, PA, PB, 1'b1);
    check_state("rst drainA", 2'b00, 1'b1, 2'd2, PA);
    drive(1'b0, 1'b0, 2'b11, PC, PD, 1'b0);
    check_state("rst during", 2'b00, 1'b1, 2'd1, PB);
    drive(1'b1, 1'b0, 2'b00, PC, PD, 1'b1);
    check_state("rst after", 2'b00, 1'b0, 2'd0, 32'h0);
    drive(1'b1, 1'b0, 2'b00, PC, PD, 1'b1);
    check_state("rst after2", 2'b00, 1'b0, 2'd0, 32'h0);

    // Random traffic against a golden queue.
    begin
      logic [31:0] q[$];
      logic [1:0]  v;
      logic [31:0] p0, p1;
      logic        ordy, fl, le, dr;
      logic [1:0]  exp_rdy;
      for (int c = 0; c < 4000; c++) begin
        v    = 2'($urandom_range(0, 3));
        p0   = $urandom;
        p1   = $urandom;
        ordy = ($urandom_range(0, 3) != 0);
        fl   = ($urandom_range(0, 49) == 0);
        drive(1'b1, fl, v, p0, p1, ordy);
        dr = (q.size() != 0) && ordy;
        le = !fl && ((q.size() == 0) || (q.size() == 1 && dr));
        exp_rdy = le ? {v[1] & v[0], v[0]} : 2'b00;
        check_state($sformatf("rand%0d", c), exp_rdy, q.size() != 0, 2'(q.size()),
                    (q.size() != 0) ? q[0] : 32'h0);
        if (fl) q.delete();
        else begin
          if (dr) void'(q.pop_front());
          if (le && v[0]) begin
            q.push_back(p0);
            if (v[1]) q.push_back(p1);
          end
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
